// File: rtl/mips_pkg.sv
// Shared defaults and the fetch-stage state encoding for the MIPS front end.
package mips_pkg;

  localparam int MEM_WORD_DEF   = 32;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int MEM_DEPTH_DEF  = 64;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO between the instruction memory and decode, with a single-cycle flush.
module fetch_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;

  // When full, wr_ptr equals rd_ptr: a push+pop overwrites the slot being read,
  // which is safe because the head is consumed on the same edge.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC drives memory directly, words buffered in a 2-entry FIFO.
// Optional out-of-range halt enabled by defining FETCH_BOUNDS_CHECK_EN.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                    MEM_WORD   = MEM_WORD_DEF,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [MEM_WORD-1:0]   imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [MEM_WORD-1:0]   instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  fault
);

  localparam int ENTRY_W = ADDR_WIDTH + MEM_WORD;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  fetch_state_e          state_q, state_d;
  logic                  fault_q, fault_d;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  logic                  out_of_range;

  assign instr_valid = !fifo_empty;
  // A redirect discards the buffer, so any handshake in that cycle is void.
  assign fifo_pop    = instr_valid && instr_ready && !redirect_valid;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  assign out_of_range = ({1'b0, pc_q} >= DEPTH_LIMIT);
`else
  assign out_of_range = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    fault_d    = fault_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      pc_d       = redirect_pc;
      state_d    = FS_RUN;
      fault_d    = 1'b0;
    end else if (state_q == FS_RUN && (!fifo_full || fifo_pop)) begin
      if (out_of_range) begin
        state_d = FS_HALT;
        fault_d = 1'b1;
      end else begin
        fifo_push = 1'b1;
        pc_d      = pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= FS_RUN;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({pc_q, imem_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign imem_addr  = pc_q;
  assign instr_pc   = fifo_head[ENTRY_W-1 -: ADDR_WIDTH];
  assign instr_data = fifo_head[MEM_WORD-1:0];
  assign fault      = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a queue model.
module tb_instr_fetch;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic        fault;

  logic [31:0] w_addr, w_data, w_idata, w_pc;
  logic        w_valid, w_fault;
  logic        w_ready = 1'b1;
  logic        w_redir = 1'b0;
  logic [31:0] w_rpc   = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Model state: buffered {pc, word} entries, fetch pointer, halt/fault flags.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit          m_halt, m_fault;

  always #5 clk = ~clk;

  assign imem_data = 32'h1000_0000 + imem_addr;
  assign w_data    = 32'h1000_0000 + w_addr;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .fault(fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_data(w_data),
    .redirect_valid(w_redir), .redirect_pc(w_rpc),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr_data(w_idata), .instr_pc(w_pc), .fault(w_fault)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_step();
    bit pop;
    bit room;
    if (!rst_n) begin
      mq.delete();
      m_pc = 32'h0;
      m_halt = 1'b0;
      m_fault = 1'b0;
      return;
    end
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc;
      m_halt = 1'b0;
      m_fault = 1'b0;
      return;
    end
    pop  = (mq.size() > 0) && instr_ready;
    room = (mq.size() < 2) || pop;
    if (pop) void'(mq.pop_front());
    if (!m_halt && room) begin
      if (BOUNDS && m_pc >= 32'd64) begin
        m_halt  = 1'b1;
        m_fault = 1'b1;
      end else begin
        mq.push_back({m_pc, 32'h1000_0000 + m_pc});
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_valid", {63'd0, instr_valid}, {63'd0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("m_pc", {32'd0, instr_pc}, {32'd0, mq[0][63:32]});
        chk("m_data", {32'd0, instr_data}, {32'd0, mq[0][31:0]});
      end
      chk("m_addr", {32'd0, imem_addr}, {32'd0, m_pc});
      chk("m_fault", {63'd0, fault}, {63'd0, m_fault});
    end
  end

  initial begin
    logic [31:0] last;
    rst_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step(3);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_pc", {32'd0, instr_pc}, 64'd0);
    chk("rst_data", {32'd0, instr_data}, 64'd0);
    chk("rst_addr", {32'd0, imem_addr}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    check_en = 1'b1;
    rst_n = 1'b1;

    // Streaming from reset, one instruction per cycle.
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("seq_valid", {63'd0, instr_valid}, 64'd1);
      chk("seq_pc", {32'd0, instr_pc}, 64'(k));
      chk("seq_data", {32'd0, instr_data}, 64'(32'h1000_0000 + k));
`ifndef FETCH_BOUNDS_CHECK_EN
      chk("wrap_pc", {32'd0, w_pc}, (k == 0) ? 64'hFFFF_FFFF : 64'(k - 1));
`endif
    end

    // Decode stall: FIFO fills with 0,1 and fetch holds at 2.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    instr_ready = 1'b0;
    step(3);
    chk("stall_pc_a", {32'd0, instr_pc}, 64'd0);
    step(2);
    chk("stall_addr", {32'd0, imem_addr}, 64'd2);
    chk("stall_pc_b", {32'd0, instr_pc}, 64'd0);
    chk("stall_data", {32'd0, instr_data}, 64'h1000_0000);
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("drain_pc", {32'd0, instr_pc}, 64'(k));
      step(1);
    end

    // Redirect while full.
    instr_ready = 1'b0;
    step(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step(1);
    redirect_valid = 1'b0;
    chk("redir_valid", {63'd0, instr_valid}, 64'd0);
    chk("redir_addr", {32'd0, imem_addr}, 64'h20);
    step(1);
    chk("redir_pc", {32'd0, instr_pc}, 64'h20);
    instr_ready = 1'b1;

    // Reset with a full FIFO.
    instr_ready = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("mid_rst_addr", {32'd0, imem_addr}, 64'd0);
    rst_n = 1'b1;
    instr_ready = 1'b1;

`ifdef FETCH_BOUNDS_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc = 32'd60;
    step(1);
    redirect_valid = 1'b0;
    last = 32'h0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (instr_valid) last = instr_pc;
    end
    chk("halt_last_pc", {32'd0, last}, 64'd63);
    chk("halt_fault", {63'd0, fault}, 64'd1);
    chk("halt_valid", {63'd0, instr_valid}, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    step(1);
    redirect_valid = 1'b0;
    chk("resume_fault", {63'd0, fault}, 64'd0);
    step(1);
    chk("resume_valid", {63'd0, instr_valid}, 64'd1);
    chk("resume_pc", {32'd0, instr_pc}, 64'd0);
`else
    last = 32'h0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(1);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 32'($urandom_range(0, 70));
      rst_n          = ($urandom_range(0, 199) != 0);
    end
    step(1);
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    step(2);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
